// File: rtl/mram_serial_pkg.sv
// Shared constants for the MRAM serial read path: word-select codes, the
// deserializer state encoding and the frame length for each word select.
package mram_serial_pkg;

    localparam logic [1:0] WORD_SEL_NONE = 2'b00;
    localparam logic [1:0] WORD_SEL_LO   = 2'b01;
    localparam logic [1:0] WORD_SEL_HI   = 2'b10;
    localparam logic [1:0] WORD_SEL_FULL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Number of serial bits in one frame: whole word or half of it.
    function automatic int unsigned frame_len(input logic [1:0] sel, input int unsigned data_w);
        return (sel == WORD_SEL_FULL) ? data_w : (data_w / 2);
    endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial receive bus plus the valid/ready word output of the deserializer.
// master: the side driving serial bits and consuming words; slave: the deserializer.
interface serial_to_parallel_if
    import mram_serial_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic              en;
    logic              start;
    logic [1:0]        word_sel;
    logic              bit_valid;
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              overrun;

    modport master (
        output en, start, word_sel, bit_valid, serial_in, data_ready,
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  en, start, word_sel, bit_valid, serial_in, data_ready,
        output data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer for the LSB-first stream of the MRAM parallel-to-serial stage.
// Collects a full word or one byte, aligns it into the word lane it came from
// and holds it in a single valid/ready output register.
module serial_to_parallel
    import mram_serial_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_to_parallel_if.slave bus
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int HALF_W = DATA_W / 2;

    // A byte frame shifts in from the top, so after HALF_W bits it sits in
    // the upper half of the shift register; move it to its own lane.
    function automatic logic [DATA_W-1:0] align_word(input logic [1:0] sel,
                                                     input logic [DATA_W-1:0] sr);
        logic [DATA_W-1:0] word;
        case (sel)
            WORD_SEL_LO: word = {{HALF_W{1'b0}}, sr[DATA_W-1 -: HALF_W]};
            WORD_SEL_HI: word = {sr[DATA_W-1 -: HALF_W], {HALF_W{1'b0}}};
            default:     word = sr;
        endcase
        return word;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        sel_q;
    logic [CNT_W-1:0]  cnt_p0;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  len_cur;
    logic [DATA_W-1:0] sr_p0;
    logic [DATA_W-1:0] sr_shift;
    logic [DATA_W-1:0] word_p1;
    logic              vld_p1;
    logic              overrun_q;
    logic              take_start;
    logic              take_bit;
    logic              last_bit;

    assign len_cur  = CNT_W'(frame_len(sel_q, DATA_W));
    assign cnt_inc  = cnt_p0 + CNT_W'(1);
    assign sr_shift = {bus.serial_in, {(DATA_W-1){1'b0}}} | (sr_p0 >> 1);

    // Next state: a legal start always (re)opens a frame and wins over a bit
    // in the same cycle; the bit that brings the count to the frame length closes it.
    always_comb begin
        state_nxt  = state;
        take_bit   = 1'b0;
        last_bit   = 1'b0;
        take_start = bus.en && bus.start && (bus.word_sel != WORD_SEL_NONE);
        case (state)
            ST_IDLE: begin
                if (take_start) begin
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (take_start) begin
                    state_nxt = ST_RECV;
                end else if (bus.en && bus.bit_valid) begin
                    take_bit = 1'b1;
                    if (cnt_inc == len_cur) begin
                        last_bit  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame capture: latch the word select on start, then shift bits in LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= WORD_SEL_NONE;
            cnt_p0 <= '0;
            sr_p0  <= '0;
        end else if (take_start) begin
            sel_q  <= bus.word_sel;
            cnt_p0 <= '0;
            sr_p0  <= '0;
        end else if (take_bit) begin
            cnt_p0 <= cnt_inc;
            sr_p0  <= sr_shift;
        end
    end

    // ---- stage p1: output holding register ----
    // A finished frame loads only if the slot is empty or being drained this
    // cycle; otherwise it is dropped and overrun latches until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_p1   <= '0;
            vld_p1    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (take_start) begin
                overrun_q <= 1'b0;
            end
            if (last_bit) begin
                if (!vld_p1 || bus.data_ready) begin
                    word_p1 <= align_word(sel_q, sr_shift);
                    vld_p1  <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (vld_p1 && bus.data_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.data_out   = word_p1;
    assign bus.data_valid = vld_p1;
    assign bus.busy       = (state == ST_RECV);
    assign bus.overrun    = overrun_q;

    // The counter stays below the frame length while a frame is open.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_RECV) |-> (cnt_p0 < len_cur));

    // An open frame always carries a legal word select.
    a_sel_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_RECV) |-> (sel_q != WORD_SEL_NONE));

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed frames followed by random per-cycle
// traffic, checked against a bit-queue reference model and a word scoreboard.
module tb_serial_to_parallel;
    import mram_serial_pkg::*;

    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_to_parallel_if #(.DATA_W(DATA_W)) bus ();

    serial_to_parallel #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits of the open frame, the one-word output slot,
    // the sticky overrun flag and the scoreboard of words still to be consumed.
    bit          m_in_frame = 1'b0;
    logic [1:0]  m_sel      = 2'b00;
    bit          m_bits[$];
    bit          m_slot     = 1'b0;
    bit          m_ovr      = 1'b0;
    logic [15:0] m_last     = 16'h0000;
    logic [15:0] exp_q[$];

    function automatic int model_len(input logic [1:0] sel);
        return (sel == 2'b11) ? 16 : 8;
    endfunction

    function automatic logic [15:0] model_word(input logic [1:0] sel);
        int w = 0;
        foreach (m_bits[i]) w = w + (int'(m_bits[i]) << i);
        if (sel == 2'b10) w = w << 8;
        return 16'(w);
    endfunction

    always @(negedge clk) begin
        bit          xfer;
        bit          done;
        logic [15:0] w;
        if (!rst_n) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_slot = 1'b0;
            m_ovr  = 1'b0;
            m_last = 16'h0000;
            exp_q.delete();
        end else begin
            check("data_valid", 32'(bus.data_valid), 32'(m_slot));
            check("busy", 32'(bus.busy), 32'(m_in_frame));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            check("data_out_hold", 32'(bus.data_out), 32'(m_last));
            xfer = m_slot && bus.data_ready;
            done = 1'b0;
            w    = 16'h0000;
            if (bus.en && bus.start && bus.word_sel != 2'b00) begin
                m_in_frame = 1'b1;
                m_sel      = bus.word_sel;
                m_bits.delete();
                m_ovr      = 1'b0;
            end else if (m_in_frame && bus.en && bus.bit_valid) begin
                m_bits.push_back(bus.serial_in);
                if (m_bits.size() == model_len(m_sel)) begin
                    done       = 1'b1;
                    m_in_frame = 1'b0;
                    w          = model_word(m_sel);
                end
            end
            if (done) begin
                if (!m_slot || xfer) begin
                    exp_q.push_back(w);
                    m_slot = 1'b1;
                    m_last = w;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer) begin
                m_slot = 1'b0;
            end
        end
    end

    // Monitor: every handshake the DUT completes must deliver the oldest expected word.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && bus.data_valid && bus.data_ready) begin
            if (exp_q.size() == 0) begin
                check("word_expected", 32'(0), 32'(1));
            end else begin
                e = exp_q.pop_front();
                check("data_out_xfer", 32'(bus.data_out), 32'(e));
                n_words++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel);
        bus.en        = 1'b1;
        bus.start     = 1'b1;
        bus.word_sel  = sel;
        bus.bit_valid = 1'b0;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                bus.bit_valid = 1'b0;
                tick();
            end
            bus.bit_valid = 1'b1;
            bus.serial_in = w[i];
            tick();
        end
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w3;
        bus.en         = 1'b0;
        bus.start      = 1'b0;
        bus.word_sel   = 2'b00;
        bus.bit_valid  = 1'b0;
        bus.serial_in  = 1'b0;
        bus.data_ready = 1'b0;
        #2;
        check("rst_data_valid", 32'(bus.data_valid), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_overrun", 32'(bus.overrun), 32'(0));
        check("rst_data_out", 32'(bus.data_out), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Full word, back-to-back bits.
        bus.data_ready = 1'b1;
        do_start(2'b11);
        send_bits(16'hA5C3, 16, 0);
        repeat (3) tick();

        // Byte frames with surplus bits after completion, and an illegal start.
        do_start(2'b01);
        send_bits(16'h033C, 10, 0);
        tick();
        do_start(2'b10);
        send_bits(16'hFFB7, 10, 0);
        tick();
        do_start(2'b00);
        send_bits(16'h1234, 16, 0);
        repeat (2) tick();

        // Sparse bits with an enable gap while bit_valid stays high.
        w3 = 16'h5A0F;
        do_start(2'b11);
        for (int i = 0; i < 16; i++) begin
            bus.bit_valid = 1'b0;
            repeat (2) tick();
            bus.bit_valid = 1'b1;
            bus.serial_in = w3[i];
            tick();
            if (i == 7) begin
                bus.en        = 1'b0;
                bus.serial_in = 1'b1;
                repeat (4) tick();
                bus.en        = 1'b1;
            end
        end
        bus.bit_valid = 1'b0;
        repeat (3) tick();

        // Back-pressure: second word is dropped and overrun latches.
        bus.data_ready = 1'b0;
        do_start(2'b11);
        send_bits(16'h1111, 16, 0);
        do_start(2'b11);
        send_bits(16'h2222, 16, 0);
        repeat (2) tick();
        check("ovr_data_out", 32'(bus.data_out), 32'h1111);
        check("ovr_flag", 32'(bus.overrun), 32'(1));
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check("ovr_drained", 32'(bus.data_valid), 32'(0));
        tick();

        // Abort after 5 bits, then a complete frame.
        bus.data_ready = 1'b1;
        do_start(2'b11);
        send_bits(16'h0013, 5, 0);
        do_start(2'b11);
        send_bits(16'hFFFF, 16, 0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a frame.
        do_start(2'b11);
        send_bits(16'h007F, 7, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data_valid", 32'(bus.data_valid), 32'(0));
        check("arst_busy", 32'(bus.busy), 32'(0));
        check("arst_overrun", 32'(bus.overrun), 32'(0));
        check("arst_data_out", 32'(bus.data_out), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        do_start(2'b11);
        send_bits(16'h8001, 16, 0);
        repeat (3) tick();

        // Random traffic on every input.
        for (int c = 0; c < 3000; c++) begin
            bus.en         = ($urandom_range(0, 9) != 0);
            bus.start      = ($urandom_range(0, 49) == 0);
            bus.word_sel   = 2'($urandom_range(0, 3));
            bus.bit_valid  = ($urandom_range(0, 9) < 6);
            bus.serial_in  = 1'($urandom_range(0, 1));
            bus.data_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        bus.en         = 1'b0;
        bus.start      = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.data_ready = 1'b1;
        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        check("words_delivered", 32'(n_words >= 10), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
